// File: rtl/bin_bcd_sevenseg_scan_if.sv
`default_nettype none
// ============================================================================
//  Module   : bin_bcd_sevenseg_scan_if
//  Brief    : Binary-in / BCD-out handshake bundle for the display driver.
//  Revision : 1.0
// ============================================================================
interface bin_bcd_sevenseg_scan_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
);
   logic [WIDTH-1:0]    in_data;
   logic                in_valid;
   logic                in_ready;
   logic [4*DIGITS-1:0] bcd;
   logic                bcd_valid;
   logic                ovf;

   modport master (
      output in_data, in_valid,
      input  in_ready, bcd, bcd_valid, ovf
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, bcd, bcd_valid, ovf
   );
endinterface
`default_nettype wire

// File: rtl/bin_bcd_sevenseg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : bin_bcd_sevenseg_scan
//  Brief    : Sequential double-dabble binary-to-BCD converter driving a
//             time-multiplexed seven-segment display with zero blanking.
//  Revision : 1.0
// ============================================================================
module bin_bcd_sevenseg_scan #(
   parameter int WIDTH      = 8,
   parameter int DIGITS     = 3,
   parameter int SCAN_DIV   = 1000,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   bin_bcd_sevenseg_scan_if.slave bus,
   input  wire logic              blank_en,
   output logic [DIGITS-1:0]      digit_en,
   output logic [6:0]             seg
);

   localparam int CNT_W  = $clog2(WIDTH);
   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [CNT_W-1:0]  c_cnt_last  = CNT_W'(WIDTH - 1);
   localparam logic [SCAN_W-1:0] c_scan_last = SCAN_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]  c_idx_last  = IDX_W'(DIGITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [WIDTH-1:0]    r_shift;
   logic [4*DIGITS-1:0] r_work;
   logic [4*DIGITS-1:0] w_adj;
   logic                r_acc;
   logic [CNT_W-1:0]    r_cnt;
   logic [4*DIGITS-1:0] r_bcd;
   logic                r_ovf;
   logic                r_bcd_valid;
   logic [SCAN_W-1:0]   r_scan;
   logic [IDX_W-1:0]    r_idx;
   logic [3:0]          w_digit;
   logic                w_blank;
   logic                w_zero_run;
   logic [DIGITS-1:0]   w_digit_onehot;
   logic [6:0]          w_seg;

   assign bus.in_ready  = (r_state == ST_IDLE);
   assign bus.bcd       = r_bcd;
   assign bus.bcd_valid = r_bcd_valid;
   assign bus.ovf       = r_ovf;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (bus.in_valid) w_state_nxt = ST_CONV;
         ST_CONV: if (r_cnt == c_cnt_last) w_state_nxt = ST_DONE;
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Add-3 correction so each digit carries into the next on the shift
   for (genvar k = 0; k < DIGITS; k++) begin : g_adj
      logic [3:0] w_d;
      assign w_d              = r_work[4*k +: 4];
      assign w_adj[4*k +: 4]  = (w_d >= 4'd5) ? (w_d + 4'd3) : w_d;
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift     <= '0;
         r_work      <= '0;
         r_acc       <= 1'b0;
         r_cnt       <= '0;
         r_bcd       <= '0;
         r_ovf       <= 1'b0;
         r_bcd_valid <= 1'b0;
      end else begin
         r_bcd_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  r_shift <= bus.in_data;
                  r_work  <= '0;
                  r_acc   <= 1'b0;
                  r_cnt   <= '0;
               end
            end
            ST_CONV: begin
               // A bit leaving the top digit is worth 10^DIGITS
               r_work  <= {w_adj[4*DIGITS-2:0], r_shift[WIDTH-1]};
               r_acc   <= r_acc | w_adj[4*DIGITS-1];
               r_shift <= {r_shift[WIDTH-2:0], 1'b0};
               r_cnt   <= r_cnt + CNT_W'(1);
            end
            ST_DONE: begin
               r_bcd       <= r_work;
               r_ovf       <= r_acc;
               r_bcd_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // --------------------------------------------------------------- scan
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scan <= '0;
         r_idx  <= '0;
      end else if (r_scan == c_scan_last) begin
         r_scan <= '0;
         r_idx  <= (r_idx == c_idx_last) ? '0 : (r_idx + IDX_W'(1));
      end else begin
         r_scan <= r_scan + SCAN_W'(1);
      end
   end

   // Walk from the top digit down so the zero run is known per position
   always_comb begin
      w_zero_run     = 1'b1;
      w_digit        = 4'd0;
      w_blank        = 1'b0;
      w_digit_onehot = '0;
      w_seg          = 7'h00;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         w_zero_run = w_zero_run && (r_bcd[4*k +: 4] == 4'd0);
         if (r_idx == IDX_W'(k)) begin
            w_digit           = r_bcd[4*k +: 4];
            w_blank           = blank_en && (k != 0) && w_zero_run;
            w_digit_onehot[k] = 1'b1;
         end
      end
      case (w_digit)
         4'd0:    w_seg = 7'h3F;
         4'd1:    w_seg = 7'h06;
         4'd2:    w_seg = 7'h5B;
         4'd3:    w_seg = 7'h4F;
         4'd4:    w_seg = 7'h66;
         4'd5:    w_seg = 7'h6D;
         4'd6:    w_seg = 7'h7D;
         4'd7:    w_seg = 7'h07;
         4'd8:    w_seg = 7'h7F;
         4'd9:    w_seg = 7'h6F;
         default: w_seg = 7'h00;
      endcase
      if (w_blank) w_seg = 7'h00;
   end

   assign seg      = ACTIVE_LOW ? ~w_seg : w_seg;
   assign digit_en = ACTIVE_LOW ? ~w_digit_onehot : w_digit_onehot;

endmodule
`default_nettype wire
